regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised, clocked successor to the LEGv8 register file: DEPTH x DATA_W storage, NUM_RD independent read ports, one write port.
- Adds registered reads, a hardwired zero register, and a hardware init sequencer that walks every entry after reset or on request.
- Sits between instruction decode (read addresses) and writeback (write port) in the datapath; the two-read-port configuration (rn/rm) is the default.

Parameters:
- DATA_W, 64, register width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- NUM_RD, 2, number of read ports, 1..4
- ZERO_IDX, 31, index of the constant-zero register (XZR); a value >= DEPTH disables the zero register
- INIT_INDEX, 1, 1 = init sequencer loads entry i with value i (zero-extended); 0 = loads all entries with 0

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, synchronous active-low reset
- init_req, input, 1, one-cycle pulse; restarts the init sequence (honoured only in IDLE)
- ready, output, 1, 1 = file initialised and accepting reads/writes
- reg_write, input, 1, write enable (REGWRITE)
- wr_addr, input, AW = $clog2(DEPTH), write register index (rd)
- wr_data, input, DATA_W, write data
- rd_addr, input, NUM_RD*AW, packed read indices; port k uses bits [k*AW +: AW]
- rd_data, output, NUM_RD*DATA_W, packed registered read data; port k uses bits [k*DATA_W +: DATA_W]

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is synchronous and active-low. Everything is updated on the rising edge of clk.
- While rst_n=0 at a clock edge:
  - state <= INIT, init_cnt <= 0, ready <= 0, all rd_data <= 0.
  - Storage is not cleared by reset itself.
- State machine has two states, INIT and IDLE.
- INIT:
  - Each edge writes mem[init_cnt] <= (INIT_INDEX ? init_cnt : 0), then init_cnt increments.
  - The edge that writes entry DEPTH-1 moves to IDLE and sets ready <= 1.
  - INIT therefore takes exactly DEPTH edges after rst_n rises.
  - In INIT, reg_write is ignored and rd_data is driven to 0.
  - init_req is ignored in INIT.
- IDLE:
  - init_req=1 sets state <= INIT, init_cnt <= 0 and ready <= 0 on that edge.
  - A reg_write on that same edge is dropped.
- Write (IDLE only): if reg_write=1 and wr_addr != ZERO_IDX, then mem[wr_addr] <= wr_data. A write to ZERO_IDX is silently discarded.
- Read (IDLE only):
  - rd_data[k] <= mem[rd_addr[k]], registered, 1-cycle latency.
  - Reading ZERO_IDX always returns 0, including during the bypass case.
  - Any number of ports may read the same address in the same cycle.
- Zero register: the init sequencer writes 0 to ZERO_IDX regardless of INIT_INDEX.
- Width rules: with INIT_INDEX=1, init value = zero-extended init_cnt. wr_addr and rd_addr are exactly AW bits, so no out-of-range addresses exist.
- Same-edge read/write to the same address: resolved per the Optional Feature below.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: if reg_write=1, wr_addr == rd_addr[k] and the address is not ZERO_IDX, then rd_data[k] <= wr_data on that edge (write-through forwarding). Writeback and decode can then share a cycle.
- Not defined: rd_data[k] <= the old mem contents (read-before-write). The new value is visible from the next read onward.

Test Plan:
- Reset/init: hold rst_n=0 for 3 edges, then release. Require ready=0 for exactly 32 edges, then ready=1. With INIT_INDEX=1, reading addr 5 returns 5, addr 30 returns 30, addr 31 returns 0.
- Basic write/read: write 64'hDEAD_BEEF_0000_0001 to addr 9, and one cycle later read addr 9 on port 0 and addr 10 on port 1. Require port 0 = 64'hDEAD_BEEF_0000_0001 and port 1 = 10, one edge after the address is applied.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31, then read 31 on both ports. Require 0 on both. Also read 31 while writing 31 in the same cycle: require 0.
- Bypass: on one edge write 64'h1234 to addr 7 while port 1 reads addr 7. With REGFILE_BYPASS_EN, require port 1 = 64'h1234. Without it, require 7, then 64'h1234 on the next read.
- init_req: after writing 64'hAA to addr 3, pulse init_req together with a write of 64'hBB to addr 4. Require ready=0 for 32 edges, the write dropped, and afterwards addr 3 reads 3 and addr 4 reads 4.
- Mid-init reset: assert rst_n=0 when init_cnt=17. Require ready=0 and rd_data=0, and after release a full 32-edge init before ready=1.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with registered reads,
// a hardwired zero register and a hardware init sequencer.
// Optional feature macro: REGFILE_BYPASS_EN. When defined, a same-edge write is
// forwarded to any read port addressing the written register (write-through).
// When undefined, reads return the old contents (read-before-write).
module regfile_mp #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_IDX   = 31,
    parameter int unsigned INIT_INDEX = 1,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_req,
    output logic                     ready,
    input  logic                     reg_write,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    // Zero register exists only when its index lies inside the file.
    localparam bit            ZeroEn   = (ZERO_IDX < DEPTH);
    localparam logic [AW-1:0] ZeroAddr = AW'(ZERO_IDX % DEPTH);
    localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e                     state_q, state_d;
    logic [AW-1:0]              init_cnt_q, init_cnt_d;
    logic                       ready_q, ready_d;
    logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;

    logic [DATA_W-1:0]          mem [DEPTH];

    logic                       mem_we;
    logic [AW-1:0]              mem_waddr;
    logic [DATA_W-1:0]          mem_wdata;

    function automatic logic is_zero(input logic [AW-1:0] addr);
        return ZeroEn && (addr == ZeroAddr);
    endfunction

    // Value the sequencer loads into entry idx; the zero register always gets 0.
    function automatic logic [DATA_W-1:0] init_value(input logic [AW-1:0] idx);
        logic [DATA_W-1:0] val;
        val = '0;
        if ((INIT_INDEX != 0) && !is_zero(idx)) begin
            val = DATA_W'(idx);
        end
        return val;
    endfunction

    // Next-state, storage write request and read-port data.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        mem_we     = 1'b0;
        mem_waddr  = init_cnt_q;
        mem_wdata  = '0;
        rd_data_d  = '0;

        unique case (state_q)
            StInit: begin
                // Walk one entry per edge; reads stay at zero, writes ignored.
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = init_value(init_cnt_q);
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == LastIdx) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end
            end

            StIdle: begin
                if (init_req) begin
                    // Restart: a write on this same edge is dropped.
                    state_d    = StInit;
                    init_cnt_d = '0;
                    ready_d    = 1'b0;
                end else if (reg_write && !is_zero(wr_addr)) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_addr;
                    mem_wdata = wr_data;
                end

                for (int k = 0; k < int'(NUM_RD); k++) begin
                    logic [AW-1:0]     ra;
                    logic [DATA_W-1:0] rv;
                    ra = rd_addr[k*AW +: AW];
                    rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
                    // mem_we is only set for a real (non-zero, non-dropped) write.
                    if (mem_we && (mem_waddr == ra)) begin
                        rv = mem_wdata;
                    end
`endif
                    if (is_zero(ra)) begin
                        rv = '0;
                    end
                    rd_data_d[k*DATA_W +: DATA_W] = rv;
                end
            end

            default: begin
                state_d    = StInit;
                init_cnt_d = '0;
                ready_d    = 1'b0;
            end
        endcase
    end

    // Control and read-data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage array; not cleared by reset, only by the init sequencer.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign ready   = ready_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp (default parameters) with an
// abstract behavioural model checked every cycle plus literal expectations.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              init_req;
    logic              ready;
    logic              reg_write;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;

    int tests = 0;
    int fails = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_req (init_req),
        .ready    (ready),
        .reg_write(reg_write),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a 32-entry array, a busy flag with a walk index, and
    // the registered read values the DUT must show after each edge.
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_rd [NR];
    logic          m_ready = 1'b0;
    logic          m_valid = 1'b0;
    bit            m_busy  = 1'b1;
    int            m_idx   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_busy  = 1'b1;
            m_idx   = 0;
            m_ready = 1'b0;
            for (int k = 0; k < NR; k++) m_rd[k] = '0;
        end else if (m_busy) begin
            m_mem[m_idx] = (m_idx == 31) ? 64'd0 : 64'(m_idx);
            for (int k = 0; k < NR; k++) m_rd[k] = '0;
            if (m_idx == 31) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end
            m_idx = m_idx + 1;
        end else begin
            bit wr_ok;
            wr_ok = reg_write && !init_req && (wr_addr != 5'd31);
            for (int k = 0; k < NR; k++) begin
                int a;
                a = int'(rd_addr[k*AW +: AW]);
                if (a == 31) m_rd[k] = '0;
`ifdef REGFILE_BYPASS_EN
                else if (wr_ok && a == int'(wr_addr)) m_rd[k] = wr_data;
`endif
                else m_rd[k] = m_mem[a];
            end
            if (init_req) begin
                m_busy  = 1'b1;
                m_idx   = 0;
                m_ready = 1'b0;
            end else if (wr_ok) begin
                m_mem[wr_addr] = wr_data;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready", {63'd0, ready}, {63'd0, m_ready});
            for (int k = 0; k < NR; k++) begin
                check($sformatf("model_rd%0d", k), rd_data[k*DW +: DW], m_rd[k]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    // Counts edges until ready rises, bounded.
    task automatic wait_ready(input string name, input int exp_edges);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            cyc();
            n++;
        end
        check(name, 64'(n), 64'(exp_edges));
    endtask

    task automatic write(input int a, input logic [DW-1:0] d);
        reg_write = 1'b1;
        wr_addr   = AW'(a);
        wr_data   = d;
        cyc();
        reg_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; init_req = 1'b0; reg_write = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset and power-up init.
        repeat (3) cyc();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_rd", rd_data[DW +: DW] | rd_data[0 +: DW], 64'd0);
        rst_n = 1'b1;
        wait_ready("init_edges", 32);

        set_rd(5, 30);
        cyc();
        check("init_a5", rd_data[0 +: DW], 64'd5);
        check("init_a30", rd_data[DW +: DW], 64'd30);
        set_rd(31, 31);
        cyc();
        check("init_a31", rd_data[0 +: DW], 64'd0);

        // Basic write then read on both ports.
        write(9, 64'hDEAD_BEEF_0000_0001);
        set_rd(9, 10);
        cyc();
        check("wr9_p0", rd_data[0 +: DW], 64'hDEAD_BEEF_0000_0001);
        check("rd10_p1", rd_data[DW +: DW], 64'd10);

        // Zero register.
        write(31, 64'hFFFF_FFFF_FFFF_FFFF);
        set_rd(31, 31);
        cyc();
        check("xzr_p0", rd_data[0 +: DW], 64'd0);
        check("xzr_p1", rd_data[DW +: DW], 64'd0);
        write(31, 64'hFFFF_FFFF_FFFF_FFFF);
        check("xzr_same_edge", rd_data[DW +: DW], 64'd0);

        // Same-edge write/read of address 7.
        set_rd(5, 7);
        write(7, 64'h1234);
`ifdef REGFILE_BYPASS_EN
        check("bypass_p1", rd_data[DW +: DW], 64'h1234);
`else
        check("rbw_p1", rd_data[DW +: DW], 64'd7);
`endif
        cyc();
        check("after_wr7_p1", rd_data[DW +: DW], 64'h1234);

        // A small pattern table through both ports.
        for (int i = 0; i < 6; i++) begin
            write(i * 5, {32'hC0DE_0000 + 32'(i), 32'(i * 3)});
        end
        for (int i = 0; i < 6; i++) begin
            set_rd(i * 5, (5 - i) * 5);
            cyc();
            check("pat_p0", rd_data[0 +: DW],
                  (i * 5 == 25 + 6) ? 64'd0 : {32'hC0DE_0000 + 32'(i), 32'(i * 3)});
        end

        // init_req restarts the walk and drops the same-edge write.
        write(3, 64'hAA);
        set_rd(3, 3);
        cyc();
        check("wr3", rd_data[0 +: DW], 64'hAA);
        init_req = 1'b1;
        write(4, 64'hBB);
        init_req = 1'b0;
        check("initreq_ready", {63'd0, ready}, 64'd0);
        wait_ready("reinit_edges", 32);
        set_rd(3, 4);
        cyc();
        check("reinit_a3", rd_data[0 +: DW], 64'd3);
        check("reinit_a4", rd_data[DW +: DW], 64'd4);

        // Reset in the middle of the walk.
        init_req = 1'b1;
        cyc();
        init_req = 1'b0;
        repeat (17) cyc();
        rst_n = 1'b0;
        cyc();
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_rd", rd_data[DW +: DW] | rd_data[0 +: DW], 64'd0);
        cyc();
        rst_n = 1'b1;
        wait_ready("midrst_edges", 32);
        set_rd(17, 18);
        cyc();
        check("midrst_a17", rd_data[0 +: DW], 64'd17);
        check("midrst_a18", rd_data[DW +: DW], 64'd18);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
